// File: rtl/iter_rshift.sv
// iter_rshift: iterative right shifter, one single-bit shift per clock.
// Accepts a WIDTH-bit operand and an SHW-bit shift amount. It shifts either
// arithmetically (MSB replicate) or logically (zero fill), and accumulates a
// sticky bit from every bit shifted out past bit 0.
//
// Ports:
//   clk        system clock, rising-edge
//   reset      synchronous active-high reset
//   in_valid   request valid          in_ready   request accepted (IDLE only)
//   a          operand                sh         shift amount (0..2^SHW-1)
//   arith      1 = arithmetic, 0 = logical
//   out_valid  result valid (DONE)    out_ready  consumer accepts result
//   dataout    shifted result         sticky     OR of bits shifted out
module iter_rshift #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   sh,
  input  logic             arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dataout,
  output logic             sticky
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_d;
  logic [SHW-1:0]   count_q, count_d;
  logic             mode_q, mode_d;
  logic             sticky_d;
  logic             in_ready_d;
  logic             out_valid_d;

  // State and datapath registers; handshake outputs are registered copies
  // of the next-state decode so neither has a combinational input path.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      dataout   <= '0;
      count_q   <= '0;
      mode_q    <= 1'b0;
      sticky    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      dataout   <= data_d;
      count_q   <= count_d;
      mode_q    <= mode_d;
      sticky    <= sticky_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    data_d   = dataout;
    count_d  = count_q;
    mode_d   = mode_q;
    sticky_d = sticky;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d   = a;
          count_d  = sh;
          mode_d   = arith;
          sticky_d = 1'b0;
          state_d  = (sh == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        // Fill bit is the current MSB in arithmetic mode, zero otherwise.
        data_d   = {mode_q & dataout[WIDTH-1], dataout[WIDTH-1:1]};
        sticky_d = sticky | dataout[0];
        count_d  = count_q - SHW'(1);
        if (count_q == SHW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

endmodule

// File: tb/tb_iter_rshift.sv
// tb_iter_rshift: directed bench for iter_rshift with an expected-result queue.
module tb_iter_rshift;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned SHW   = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [SHW-1:0]   sh;
  logic             arith;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dataout;
  logic             sticky;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             s;
    int               lat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  iter_rshift #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .sh        (sh),
    .arith     (arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dataout   (dataout),
    .sticky    (sticky)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: independent of the iterative datapath.
  function automatic exp_t model(input logic [WIDTH-1:0] av, input int shv, input logic ar);
    exp_t e;
    logic [WIDTH-1:0] mask;
    mask  = (WIDTH'(1) << shv) - WIDTH'(1);
    e.d   = ar ? WIDTH'($signed(av) >>> shv) : (av >> shv);
    e.s   = ((av & mask) != '0);
    e.lat = shv + 1;
    return e;
  endfunction

  // Present one request in IDLE and take the acceptance edge (cycle 0).
  task automatic send(input logic [WIDTH-1:0] av, input int shv, input logic ar, input bit push);
    chk("in_ready_before_send", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a        = av;
    sh       = SHW'(shv);
    arith    = ar;
    tick();
    in_valid = 1'b0;
    a        = $urandom();
    sh       = SHW'($urandom());
    arith    = 1'($urandom());
    if (push) q.push_back(model(av, shv, ar));
  endtask

  // Wait (bounded) for out_valid, then compare against the queue head.
  task automatic collect(input string tag);
    exp_t e;
    int   cyc;
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    if (q.size() == 0) begin
      chk({tag, "_queue_nonempty"}, 32'(q.size()), 32'd1);
    end else begin
      e = q.pop_front();
      chk({tag, "_latency"}, 32'(cyc), 32'(e.lat));
      chk({tag, "_dataout"}, 32'(dataout), 32'(e.d));
      chk({tag, "_sticky"}, 32'(sticky), 32'(e.s));
    end
  endtask

  // Complete the output handshake and confirm return to IDLE.
  task automatic drain(input string tag);
    out_ready = 1'b1;
    tick();
    chk({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    sh        = '0;
    arith     = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_dataout", 32'(dataout), 32'h0);
    chk("rst_sticky", 32'(sticky), 32'd0);

    // Reset in the middle of a shift discards the operation.
    send(16'h8001, 8, 1'b1, 1'b0);
    tick();
    tick();
    chk("mid_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_dataout", 32'(dataout), 32'h0);
    chk("midrst_sticky", 32'(sticky), 32'd0);
    send(16'h8001, 8, 1'b1, 1'b1);
    collect("post_rst");
    chk("post_rst_const", 32'(dataout), 32'h0000_FF80);
    drain("post_rst");

    // Arithmetic shift.
    send(16'h8001, 4, 1'b1, 1'b1);
    collect("arith4");
    chk("arith4_const", 32'(dataout), 32'h0000_F800);
    drain("arith4");

    // Logical shift.
    send(16'h8001, 4, 1'b0, 1'b1);
    collect("logic4");
    chk("logic4_const", 32'(dataout), 32'h0000_0800);
    drain("logic4");

    // Zero shift.
    send(16'h1234, 0, 1'b1, 1'b1);
    collect("zero");
    chk("zero_const", 32'(dataout), 32'h0000_1234);
    drain("zero");

    // Maximum shifts.
    send(16'h7FFF, 15, 1'b1, 1'b1);
    collect("max_pos");
    chk("max_pos_const", 32'(dataout), 32'h0);
    drain("max_pos");
    send(16'h8000, 15, 1'b1, 1'b1);
    collect("max_neg");
    chk("max_neg_const", 32'(dataout), 32'h0000_FFFF);
    drain("max_neg");

    // Backpressure with an ignored request pulse during DONE.
    out_ready = 1'b0;
    send(16'h00F0, 4, 1'b0, 1'b1);
    collect("bp");
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        in_valid = 1'b1;
        a        = 16'hFFFF;
        sh       = 4'd1;
        arith    = 1'b1;
      end
      tick();
      in_valid = 1'b0;
      chk("bp_hold_out_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_dataout", 32'(dataout), 32'h0000_000F);
      chk("bp_hold_sticky", 32'(sticky), 32'd0);
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    drain("bp");
    tick();
    chk("bp_no_exec_in_ready", 32'(in_ready), 32'd1);
    chk("bp_no_exec_out_valid", 32'(out_valid), 32'd0);
    chk("bp_queue_empty", 32'(q.size()), 32'd0);

    // A few random operands through the same scoreboard.
    for (int i = 0; i < 8; i++) begin
      send(WIDTH'($urandom()), int'($urandom_range(0, 15)), 1'($urandom()), 1'b1);
      collect("rand");
      drain("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
